// File: rtl/serial_frame_tx_pkg.sv
// serial_frame_tx_pkg: shared types and constants for the serial frame transmitter.
//   state_e  - transmitter FSM state encoding
//   SEG_LUT  - hex digit to 7-segment pattern {a,b,c,d,e,f,g}, active-high
//   hex2seg  - LUT lookup helper
package serial_frame_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // Index 0 sits in the least significant slot, so entry F is listed first.
  localparam logic [15:0][6:0] SEG_LUT = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    return SEG_LUT[h];
  endfunction

endpackage

// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if: request/serial-line bundle of the frame transmitter.
//   start, x, din : request side (driven by master)
//   sout, busy, done, seg : transmitter status and serial line (driven by slave)
interface serial_frame_tx_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             x;
  logic [WIDTH-1:0] din;
  logic             sout;
  logic             busy;
  logic             done;
  logic [6:0]       seg;

  modport master (output start, x, din, input sout, busy, done, seg);
  modport slave  (input start, x, din, output sout, busy, done, seg);
endinterface

// File: rtl/serial_frame_tx_hex_to_seg7.sv
// hex_to_seg7: combinational hex digit to 7-segment decoder.
//   hex_i : 4-bit digit
//   seg_o : segments {a,b,c,d,e,f,g}, active-high
module hex_to_seg7
  import serial_frame_tx_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);
  assign seg_o = hex2seg(hex_i);
endmodule

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: framed serial transmitter (start bit, WIDTH data bits, stop bit).
//   clk   : system clock, rising edge
//   reset : synchronous active-low reset
//   bus   : slave side of serial_frame_tx_if
//           start/x/din in, sout/busy/done/seg out
// Each serial bit is held for BIT_CYCLES clocks. Bit order is latched from x
// at acceptance (1 = MSB-first). seg shows the digit captured at acceptance.
module serial_frame_tx
  import serial_frame_tx_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int BIT_CYCLES = 1
) (
  input logic              clk,
  input logic              reset,
  serial_frame_tx_if.slave bus
);
  localparam int BCW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BNW = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0] BC_LAST  = BCW'(BIT_CYCLES - 1);
  localparam logic [BNW-1:0] BIT_LAST = BNW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             order_q, order_d;
  logic [3:0]       disp_q, disp_d;
  logic [BCW-1:0]   bcnt_q, bcnt_d;
  logic [BNW-1:0]   bitn_q, bitn_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      order_q <= 1'b0;
      disp_q  <= '0;
      bcnt_q  <= '0;
      bitn_q  <= '0;
      sout_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      order_q <= order_d;
      disp_q  <= disp_d;
      bcnt_q  <= bcnt_d;
      bitn_q  <= bitn_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    order_d = order_q;
    disp_d  = disp_q;
    bcnt_d  = bcnt_q;
    bitn_d  = bitn_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          shift_d = bus.din;
          order_d = bus.x;
          disp_d  = 4'(bus.din);
          bcnt_d  = '0;
          bitn_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (bcnt_q == BC_LAST) begin
          bcnt_d  = '0;
          state_d = DATA;
        end else begin
          bcnt_d = bcnt_q + BCW'(1);
        end
      end
      DATA: begin
        if (bcnt_q == BC_LAST) begin
          bcnt_d  = '0;
          // Move the next bit toward the output end; vacated bits fill with 0.
          shift_d = order_q ? (shift_q << 1) : (shift_q >> 1);
          bitn_d  = bitn_q + BNW'(1);
          if (bitn_q == BIT_LAST) state_d = STOP;
        end else begin
          bcnt_d = bcnt_q + BCW'(1);
        end
      end
      STOP: begin
        if (bcnt_q == BC_LAST) begin
          bcnt_d  = '0;
          state_d = IDLE;
        end else begin
          bcnt_d = bcnt_q + BCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the
  // state they describe, with no input-to-output combinational path.
  always_comb begin
    sout_d = 1'b1;
    unique case (state_d)
      START:   sout_d = 1'b0;
      DATA:    sout_d = order_d ? shift_d[WIDTH-1] : shift_d[0];
      default: sout_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == STOP) && (state_d == IDLE);
  end

  hex_to_seg7 u_seg (
    .hex_i (disp_q),
    .seg_o (bus.seg)
  );

  assign bus.sout = sout_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
module tb_serial_frame_tx;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_frame_tx_if #(.WIDTH(4)) b0 ();
  serial_frame_tx_if #(.WIDTH(4)) b1 ();

  serial_frame_tx #(.WIDTH(4), .BIT_CYCLES(1)) dut0 (.clk(clk), .reset(rst_n), .bus(b0));
  serial_frame_tx #(.WIDTH(4), .BIT_CYCLES(3)) dut1 (.clk(clk), .reset(rst_n), .bus(b1));

  // Hand-copied segment table, 0..F
  logic [6:0] segt [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                            7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  int chk_cnt = 0;
  int pass_cnt = 0;

  bit q0[$], q1[$];          // expected sout per busy cycle
  int sq0[$], sq1[$];        // expected seg at first busy cycle
  int lq0[$], lq1[$];        // expected busy length per frame

  task automatic chk(input string nm, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- monitors ----------------
  int  len0 = 0, len1 = 0;
  bit  pb0 = 0, pb1 = 0;

  always @(negedge clk) begin
    if (b0.busy) begin
      if (!pb0) begin
        if (sq0.size() == 0) begin chk_cnt++; $display("FAIL seg0: unexpected frame, seg %0d", b0.seg); end
        else chk("seg0", int'(b0.seg), sq0.pop_front());
      end
      if (q0.size() == 0) begin chk_cnt++; $display("FAIL sout0: unexpected busy cycle, sout %0d", b0.sout); end
      else chk("sout0", int'(b0.sout), int'(q0.pop_front()));
      len0++;
    end else begin
      if (b0.done) begin
        if (lq0.size() == 0) begin chk_cnt++; $display("FAIL done0: unexpected done, len %0d", len0); end
        else chk("busylen0", len0, lq0.pop_front());
        chk("done_sout0", int'(b0.sout), 1);
      end
      len0 = 0;
    end
    pb0 = b0.busy;
  end

  always @(negedge clk) begin
    if (b1.busy) begin
      if (!pb1) begin
        if (sq1.size() == 0) begin chk_cnt++; $display("FAIL seg1: unexpected frame, seg %0d", b1.seg); end
        else chk("seg1", int'(b1.seg), sq1.pop_front());
      end
      if (q1.size() == 0) begin chk_cnt++; $display("FAIL sout1: unexpected busy cycle, sout %0d", b1.sout); end
      else chk("sout1", int'(b1.sout), int'(q1.pop_front()));
      len1++;
    end else begin
      if (b1.done) begin
        if (lq1.size() == 0) begin chk_cnt++; $display("FAIL done1: unexpected done, len %0d", len1); end
        else chk("busylen1", len1, lq1.pop_front());
        chk("done_sout1", int'(b1.sout), 1);
      end
      len1 = 0;
    end
    pb1 = b1.busy;
  end

  // ---------------- expectation builders ----------------
  // Literal 6-bit waveform for BIT_CYCLES=1, first bit in bit 5.
  task automatic push_lit0(input logic [5:0] w, input int d);
    for (int i = 5; i >= 0; i--) q0.push_back(w[i]);
    sq0.push_back(int'(segt[d]));
    lq0.push_back(6);
  endtask

  task automatic push_model(input int dut, input logic [3:0] d, input logic xo);
    int bc;
    bit b;
    bc = (dut == 0) ? 1 : 3;
    for (int k = -1; k <= 4; k++) begin
      if (k < 0)       b = 1'b0;
      else if (k == 4) b = 1'b1;
      else             b = xo ? d[3-k] : d[k];
      for (int c = 0; c < bc; c++) begin
        if (dut == 0) q0.push_back(b); else q1.push_back(b);
      end
    end
    if (dut == 0) begin sq0.push_back(int'(segt[d])); lq0.push_back(6 * bc); end
    else          begin sq1.push_back(int'(segt[d])); lq1.push_back(6 * bc); end
  endtask

  task automatic req0(input logic [3:0] d, input logic xo);
    b0.start = 1'b1; b0.din = d; b0.x = xo;
    tick();
    b0.start = 1'b0;
  endtask

  task automatic req1(input logic [3:0] d, input logic xo);
    b1.start = 1'b1; b1.din = d; b1.x = xo;
    tick();
    b1.start = 1'b0;
  endtask

  task automatic wait_idle(input int dut);
    int n;
    n = 0;
    while (((dut == 0) ? b0.busy : b1.busy) && n < 200) begin tick(); n++; end
    if (n >= 200) begin chk_cnt++; $display("FAIL wait_idle%0d: still busy after %0d cycles", dut, n); end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, dn;
    rst_n = 1'b0;
    b0.start = 0; b0.x = 0; b0.din = '0;
    b1.start = 0; b1.x = 0; b1.din = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_sout0", int'(b0.sout), 1); chk("rst_busy0", int'(b0.busy), 0);
    chk("rst_done0", int'(b0.done), 0); chk("rst_seg0", int'(b0.seg), 7'h7E);
    chk("rst_sout1", int'(b1.sout), 1); chk("rst_busy1", int'(b1.busy), 0);
    chk("rst_done1", int'(b1.done), 0); chk("rst_seg1", int'(b1.seg), 7'h7E);
    tick();

    // MSB-first and LSB-first, din=1011
    push_lit0(6'b010111, 11); req0(4'b1011, 1'b1); wait_idle(0);
    tick();
    push_lit0(6'b011011, 11); req0(4'b1011, 1'b0); wait_idle(0);
    tick();

    // Start pulse mid-frame is ignored; din/x toggles mid-frame have no effect
    push_lit0(6'b010101, 10); req0(4'hA, 1'b1);
    b0.din = 4'h3; b0.x = 1'b0; tick();
    b0.start = 1'b1; tick(); b0.start = 1'b0;
    wait_idle(0);
    tick();

    // Back-to-back with start held high, din=1111
    for (int f = 0; f < 3; f++) push_lit0(6'b011111, 15);
    b0.start = 1'b1; b0.din = 4'hF; b0.x = 1'b1;
    tick();
    dn = 0; n = 0;
    while (dn < 2 && n < 100) begin
      tick(); n++;
      if (b0.done) begin
        dn++;
        tick();
        chk("b2b_busy", int'(b0.busy), 1);
      end
    end
    b0.start = 1'b0;
    if (n >= 100) begin chk_cnt++; $display("FAIL b2b: done count %0d after %0d cycles", dn, n); end
    wait_idle(0);
    tick();

    // Display sweep
    for (int d = 0; d < 16; d++) begin
      push_model(0, 4'(d), 1'b0);
      req0(4'(d), 1'b0);
      wait_idle(0);
    end
    tick();

    // Stretched bits with mid-frame toggling of din/x
    push_model(1, 4'b0110, 1'b1); req1(4'b0110, 1'b1);
    n = 0;
    while (b1.busy && n < 100) begin b1.din = ~b1.din; b1.x = ~b1.x; tick(); n++; end
    wait_idle(1);
    push_model(1, 4'b1001, 1'b0); req1(4'b1001, 1'b0); wait_idle(1);
    tick();

    // Reset mid-frame, with start held during reset
    push_model(0, 4'h6, 1'b1); req0(4'h6, 1'b1);
    repeat (3) tick();
    rst_n = 1'b0; b0.start = 1'b1; b0.din = 4'h5;
    tick();
    q0.delete(); lq0.delete(); sq0.delete();
    @(negedge clk);
    chk("mrst_sout", int'(b0.sout), 1); chk("mrst_busy", int'(b0.busy), 0);
    chk("mrst_done", int'(b0.done), 0); chk("mrst_seg", int'(b0.seg), 7'h7E);
    tick();
    rst_n = 1'b1; b0.start = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk("post_rst_busy", int'(b0.busy), 0);
    chk("post_rst_seg", int'(b0.seg), 7'h7E);
    tick();

    chk("q0_left", q0.size() + sq0.size() + lq0.size(), 0);
    chk("q1_left", q1.size() + sq1.size() + lq1.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

- Serial transmitter for the 4-bit counter datapath.
- Captures a parallel nibble (e.g. a counter value) on a start request and shifts it out on a single line as a framed word: start bit, data bits, stop bit.
- Data bit order is selectable by `x`, mirroring the up/down select on the counter.
- Shows the captured value on the 7-segment output while it transmits.

## Interface
Parameters:
- `WIDTH`, 4, number of data bits per frame.
- `BIT_CYCLES`, 1, clock cycles each serial bit is held on `sout` (must be ≥1).

Ports:
- `clk`  input  1  single system clock; all logic updates on its rising edge.
- `reset`  input  1  synchronous, active-low reset; sampled on rising `clk`.
- `start`  input  1  transmit request; sampled only in IDLE.
- `x`  input  1  bit order: 1 = MSB-first, 0 = LSB-first; captured together with `din`.
- `din`  input  WIDTH  parallel data to send.
- `sout`  output  1  serial line; idles high.
- `busy`  output  1  high from the cycle after acceptance until the frame completes.
- `done`  output  1  one-cycle pulse at frame completion.
- `seg`  output  7  segments {a,b,c,d,e,f,g} = `seg[6:0]`, active-high; show the hex digit of the captured data (low 4 bits).

## Operation
- State machine has four states: IDLE, START, DATA, STOP.
- **IDLE:**
  - `sout`=1, `busy`=0.
  - If `start`=1, latch `din` into the shift register and `x` into the order flag, then go to START.
- **START:**
  - `sout`=0 for `BIT_CYCLES` cycles, then go to DATA.
- **DATA:**
  - `sout` = shift register MSB (order flag 1) or LSB (order flag 0), held for `BIT_CYCLES` cycles.
  - After each bit, shift toward the output end, zero-fill, and increment the bit counter.
  - After `WIDTH` bits, go to STOP.
- **STOP:**
  - `sout`=1 for `BIT_CYCLES` cycles, then go to IDLE.
  - `done`=1 for exactly that return cycle (the first IDLE cycle).
- `busy`=1 in START, DATA and STOP.
- Changes to `din` and `x` during a frame have no effect.
- `start` while busy is ignored; requests are not queued.
- `start`=1 in the same cycle `done`=1 is accepted, because the block is already in IDLE. This gives back-to-back frames with exactly one idle-high cycle between stop and the next start bit.
- `seg` decodes a separate display latch loaded at acceptance; it does not decode the shifting register.
  - Hex patterns: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Bit-cycle counter width is clog2(`BIT_CYCLES`). Bit counter width is clog2(`WIDTH`+1). Neither counter wraps mid-frame.
- **Reset (`reset`=0 at a rising edge):** from any state, including mid-frame, the block returns to IDLE. Reset values:
  - `sout`=1, `busy`=0, `done`=0.
  - Shift register, display latch and counters = 0.
  - `seg`=1111110.
  - A `start` coinciding with reset is dropped.

## Timing
- Acceptance at edge T.
- START bit occupies cycles T+1 … T+`BIT_CYCLES`.
- Data bit k (k=0..WIDTH−1) begins at T+1+(k+1)·`BIT_CYCLES`.
- STOP bit begins at T+1+(WIDTH+1)·`BIT_CYCLES`.
- `done` is high and `busy` low at T+1+(WIDTH+2)·`BIT_CYCLES`.
- `busy` is high for exactly (WIDTH+2)·`BIT_CYCLES` cycles.
- `seg` updates at T+1.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package/include holds:
  - state encodings (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3);
  - the 16-entry hex-to-segment constants, reused by the counter and display blocks.
- One sub-module: `hex_to_seg7` (4-bit in, 7-bit registered-free combinational out, driven from the display latch).
- Top holds the FSM, shift register, bit-cycle counter and bit counter.

## Test plan
- Reset mid-frame: pull `reset` low during DATA -> next edge `sout`=1, `busy`=0, `seg`=1111110. A `start` held during reset produces no frame.
- MSB-first, `BIT_CYCLES`=1: `din`=1011, `x`=1, `start` pulse -> `sout` = 0,1,0,1,1,1 over 6 cycles. `busy` is high for those 6 cycles, then `done` pulses once and `seg`=0011111 (b).
- LSB-first, `BIT_CYCLES`=1: `din`=1011, `x`=0 -> `sout` = 0,1,1,0,1,1.
- Stretched bits: `BIT_CYCLES`=3, `din`=0110, `x`=1 -> each bit is held 3 cycles. `busy` is high for 18 cycles. Toggling `din` and `x` mid-frame leaves the waveform unchanged.
- Busy/back-to-back:
  - `start` held high continuously with `din`=1111 -> frames repeat with exactly one idle-high cycle between them.
  - A `start` pulse mid-frame is ignored.
- Display sweep: send `din`=0..F -> `seg` matches the hex table at T+1 of each acceptance.
